// File: rtl/spmm_pkg.sv
// Shared SpMM types and dimensions: matrix size, element type, row/beat payloads
// and the bank / transmit state encodings.
package spmm_pkg;

  localparam int unsigned N        = 16;
  localparam int unsigned W        = 8;
  localparam int unsigned LG_N     = $clog2(N);
  localparam int unsigned BEATS    = N / 4;
  localparam int unsigned LG_BEATS = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [W-1:0] data;
  } data_t;

  typedef data_t [N-1:0] row_t;
  typedef row_t  [3:0]   beat_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_BURST,
    TX_GAP
  } tx_state_t;

endpackage

// File: rtl/rhs_bank.sv
// One N x N matrix bank: row-wide write port, combinational 4-row beat read port.
module rhs_bank
  import spmm_pkg::*;
(
  input  logic                clock,
  input  logic                we,
  input  logic [LG_N-1:0]     row_idx,
  input  row_t                row,
  input  logic [LG_BEATS-1:0] beat_idx,
  output beat_t               beat_data
);

  row_t mem [N];

  always_ff @(posedge clock) begin
    if (we) mem[row_idx] <= row;
  end

  // Beat k lane i is row 4k+i.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      beat_data[i] = mem[LG_N'(4 * int'(beat_idx) + i)];
    end
  end

endmodule

// File: rtl/rhs_streamer.sv
// SpMM RHS transmit side: ping-pong matrix banks filled a row per cycle and
// streamed as N/4-beat bursts followed by a one-cycle gap.
module rhs_streamer
  import spmm_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  row_t       wr_row,
  input  logic       rhs_ready,
  output logic       rhs_start,
  output beat_t      rhs_data,
  output logic       tx_busy,
  output logic [1:0] full_cnt
);

  bank_state_t         bank_st [2];
  logic [LG_N-1:0]     wr_cnt;
  logic                wr_bank;
  logic                rd_bank;
  logic [LG_BEATS-1:0] beat;
  logic [LG_BEATS-1:0] rd_beat;
  tx_state_t           tx_state;
  beat_t               rd_data [2];
  logic                wr_fire;
  logic                fill;
  logic                free;

  assign wr_ready = (bank_st[wr_bank] != BANK_FULL);
  assign wr_fire  = wr_valid && wr_ready;
  assign fill     = wr_fire && (wr_cnt == LG_N'(N - 1));
  assign free     = (tx_state == TX_BURST) && (beat == LG_BEATS'(BEATS - 1));

  // Output data is registered, so the read port looks one beat ahead.
  assign rd_beat  = (tx_state == TX_BURST) ? beat + LG_BEATS'(1) : '0;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    rhs_bank u_bank (
      .clock     (clock),
      .we        (wr_fire && (wr_bank == 1'(k))),
      .row_idx   (wr_cnt),
      .row       (wr_row),
      .beat_idx  (rd_beat),
      .beat_data (rd_data[k])
    );
  end

  // Write side and bank bookkeeping; a bank being written is never the one freed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      full_cnt   <= 2'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_fire && (wr_bank == 1'(k))) begin
          bank_st[k] <= fill ? BANK_FULL : BANK_FILLING;
        end else if (free && (rd_bank == 1'(k))) begin
          bank_st[k] <= BANK_EMPTY;
        end
      end
      if (wr_fire) begin
        wr_cnt <= fill ? '0 : wr_cnt + LG_N'(1);
        if (fill) wr_bank <= ~wr_bank;
      end
      full_cnt <= full_cnt + 2'(fill) - 2'(free);
    end
  end

  // Transmit FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      rd_bank   <= 1'b0;
      beat      <= '0;
      rhs_start <= 1'b0;
      rhs_data  <= '0;
      tx_busy   <= 1'b0;
    end else begin
      rhs_start <= 1'b0;
      rhs_data  <= '0;
      case (tx_state)
        TX_IDLE: begin
          if ((bank_st[rd_bank] == BANK_FULL) && rhs_ready) begin
            tx_state  <= TX_BURST;
            beat      <= '0;
            rhs_start <= 1'b1;
            rhs_data  <= rd_data[rd_bank];
            tx_busy   <= 1'b1;
          end
        end
        TX_BURST: begin
          if (free) begin
            tx_state <= TX_GAP;
            rd_bank  <= ~rd_bank;
          end else begin
            beat     <= beat + LG_BEATS'(1);
            rhs_data <= rd_data[rd_bank];
          end
        end
        TX_GAP: begin
          tx_state <= TX_IDLE;
          tx_busy  <= 1'b0;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rhs_streamer.sv
// Directed bench for rhs_streamer: burst timing/content, backpressure, ping-pong,
// fill/free overlap, mid-burst reset and gapped writes.
module tb_rhs_streamer;
  import spmm_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  row_t       wr_row;
  logic       rhs_ready;
  logic       rhs_start;
  beat_t      rhs_data;
  logic       tx_busy;
  logic [1:0] full_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  rhs_streamer dut (
    .clock     (clock),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .rhs_ready (rhs_ready),
    .rhs_start (rhs_start),
    .rhs_data  (rhs_data),
    .tx_busy   (tx_busy),
    .full_cnt  (full_cnt)
  );

  // Row r of matrix "seed": element j = r*16 + j + seed (mod 256).
  function automatic row_t mk_row(int r, int seed);
    row_t v;
    for (int j = 0; j < N; j++) v[j].data = W'(r * 16 + j + seed);
    return v;
  endfunction

  function automatic beat_t exp_beat(int seed, int k);
    beat_t v;
    for (int i = 0; i < 4; i++) v[i] = mk_row(4 * k + i, seed);
    return v;
  endfunction

  // Called at a negedge; the row is offered for exactly one rising edge.
  task automatic write_row(input row_t v);
    wr_valid = 1'b1;
    wr_row   = v;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; rhs_ready = 1'b0; wr_row = '0;
    repeat (2) @(negedge clock);
    tests++; if ({rhs_start, tx_busy, full_cnt, wr_ready} !== 5'b00001) begin
      fails++; $display("FAIL reset_ctrl: got start/busy/full/wr_ready %b exp 00001", {rhs_start, tx_busy, full_cnt, wr_ready}); end
    tests++; if (rhs_data !== '0) begin
      fails++; $display("FAIL reset_data: got %h exp 0", rhs_data); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    rhs_ready = 1'b1;
    for (int r = 0; r < 16; r++) write_row(mk_row(r, 0));
    tests++; if ({rhs_start, full_cnt} !== 3'b001) begin
      fails++; $display("FAIL basic_pre: got start/full %b exp 001", {rhs_start, full_cnt}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests++; if ({rhs_start, tx_busy} !== {1'(k == 0), 1'b1}) begin
        fails++; $display("FAIL basic_start beat%0d: got start/busy %b exp %b1", k, {rhs_start, tx_busy}, k == 0); end
      tests++; if (rhs_data !== exp_beat(0, k)) begin
        fails++; $display("FAIL basic_data beat%0d: got %h exp %h", k, rhs_data, exp_beat(0, k)); end
    end
    @(negedge clock);
    tests++; if (rhs_data !== '0 || {rhs_start, tx_busy, full_cnt} !== 4'b0100) begin
      fails++; $display("FAIL basic_gap: got start/busy/full %b data %h exp 0100 data 0", {rhs_start, tx_busy, full_cnt}, rhs_data); end
    @(negedge clock);
    tests++; if ({rhs_start, tx_busy} !== 2'b00) begin
      fails++; $display("FAIL basic_idle: got start/busy %b exp 00", {rhs_start, tx_busy}); end
  endtask

  task automatic test_backpressure();
    rhs_ready = 1'b0;
    for (int r = 0; r < 16; r++) write_row(mk_row(r, 1));
    repeat (10) begin
      @(negedge clock);
      tests++; if ({rhs_start, full_cnt} !== 3'b001) begin
        fails++; $display("FAIL bp_hold: got start/full %b exp 001", {rhs_start, full_cnt}); end
    end
    rhs_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests++; if (rhs_start !== 1'(k == 0) || rhs_data !== exp_beat(1, k)) begin
        fails++; $display("FAIL bp_beat%0d: got start %b data %h exp start %b data %h", k, rhs_start, rhs_data, k == 0, exp_beat(1, k)); end
    end
    @(negedge clock);
    tests++; if (rhs_data !== '0 || full_cnt !== 2'd0) begin
      fails++; $display("FAIL bp_gap: got full %0d data %h exp full 0 data 0", full_cnt, rhs_data); end
    @(negedge clock);
  endtask

  task automatic test_ping_pong();
    rhs_ready = 1'b0;
    for (int r = 0; r < 32; r++) write_row(mk_row(r % 16, (r < 16) ? 2 : 3));
    tests++; if ({full_cnt, wr_ready} !== 3'b100) begin
      fails++; $display("FAIL pp_full: got full/wr_ready %b exp 100", {full_cnt, wr_ready}); end
    write_row(mk_row(0, 99));
    tests++; if ({full_cnt, wr_ready} !== 3'b100) begin
      fails++; $display("FAIL pp_ignore: got full/wr_ready %b exp 100", {full_cnt, wr_ready}); end
    rhs_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clock);
        tests++; if (rhs_start !== 1'(k == 0) || full_cnt !== 2'(2 - b)) begin
          fails++; $display("FAIL pp_ctrl b%0d beat%0d: got start %b full %0d exp start %b full %0d", b, k, rhs_start, full_cnt, k == 0, 2 - b); end
        tests++; if (rhs_data !== exp_beat(2 + b, k)) begin
          fails++; $display("FAIL pp_data b%0d beat%0d: got %h exp %h", b, k, rhs_data, exp_beat(2 + b, k)); end
      end
      @(negedge clock);
      tests++; if (rhs_data !== '0 || full_cnt !== 2'(1 - b) || wr_ready !== 1'b1) begin
        fails++; $display("FAIL pp_gap b%0d: got full %0d wr_ready %b data %h exp full %0d wr_ready 1 data 0", b, full_cnt, wr_ready, rhs_data, 1 - b); end
      @(negedge clock);
      tests++; if ({rhs_start, tx_busy} !== 2'b00) begin
        fails++; $display("FAIL pp_idle b%0d: got start/busy %b exp 00", b, {rhs_start, tx_busy}); end
    end
  endtask

  task automatic test_overlap();
    rhs_ready = 1'b0;
    for (int r = 0; r < 16; r++) write_row(mk_row(r, 4));
    for (int r = 0; r < 15; r++) write_row(mk_row(r, 5));
    tests++; if ({full_cnt, wr_ready} !== 3'b011) begin
      fails++; $display("FAIL ov_pre: got full/wr_ready %b exp 011", {full_cnt, wr_ready}); end
    rhs_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests++; if (rhs_start !== 1'(k == 0) || rhs_data !== exp_beat(4, k)) begin
        fails++; $display("FAIL ov_a_beat%0d: got start %b data %h exp start %b data %h", k, rhs_start, rhs_data, k == 0, exp_beat(4, k)); end
    end
    // Last row of the second bank lands on the edge that frees the first.
    wr_valid = 1'b1;
    wr_row   = mk_row(15, 5);
    @(negedge clock);
    wr_valid = 1'b0;
    tests++; if (full_cnt !== 2'd1 || rhs_data !== '0) begin
      fails++; $display("FAIL ov_full_cnt: got full %0d data %h exp full 1 data 0", full_cnt, rhs_data); end
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests++; if (rhs_start !== 1'(k == 0) || rhs_data !== exp_beat(5, k)) begin
        fails++; $display("FAIL ov_b_beat%0d: got start %b data %h exp start %b data %h", k, rhs_start, rhs_data, k == 0, exp_beat(5, k)); end
    end
    @(negedge clock);
    tests++; if (full_cnt !== 2'd0) begin
      fails++; $display("FAIL ov_gap: got full %0d exp 0", full_cnt); end
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    rhs_ready = 1'b1;
    for (int r = 0; r < 16; r++) write_row(mk_row(r, 6));
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      tests++; if (rhs_data !== exp_beat(6, k)) begin
        fails++; $display("FAIL mr_beat%0d: got %h exp %h", k, rhs_data, exp_beat(6, k)); end
      wr_valid = (k < 2);
      wr_row   = mk_row(k, 8);
    end
    #1 reset = 1'b1;
    #1;
    tests++; if ({rhs_start, tx_busy, full_cnt, wr_ready} !== 5'b00001 || rhs_data !== '0) begin
      fails++; $display("FAIL mr_async: got start/busy/full/wr_ready %b data %h exp 00001 data 0", {rhs_start, tx_busy, full_cnt, wr_ready}, rhs_data); end
    @(negedge clock);
    reset = 1'b0;
    for (int r = 0; r < 8; r++) write_row(mk_row(r, 7));
    repeat (6) begin
      @(negedge clock);
      tests++; if ({rhs_start, tx_busy} !== 2'b00) begin
        fails++; $display("FAIL mr_no_burst: got start/busy %b exp 00", {rhs_start, tx_busy}); end
    end
    for (int r = 8; r < 16; r++) write_row(mk_row(r, 7));
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests++; if (rhs_start !== 1'(k == 0) || rhs_data !== exp_beat(7, k)) begin
        fails++; $display("FAIL mr_new_beat%0d: got start %b data %h exp start %b data %h", k, rhs_start, rhs_data, k == 0, exp_beat(7, k)); end
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_wr_gaps();
    rhs_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      write_row(mk_row(r, 0));
      if (r < 15) repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    tests++; if (rhs_start !== 1'b0) begin
      fails++; $display("FAIL gaps_pre: got start %b exp 0", rhs_start); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests++; if (rhs_start !== 1'(k == 0) || rhs_data !== exp_beat(0, k)) begin
        fails++; $display("FAIL gaps_beat%0d: got start %b data %h exp start %b data %h", k, rhs_start, rhs_data, k == 0, exp_beat(0, k)); end
    end
    @(negedge clock);
    tests++; if (rhs_data !== '0 || tx_busy !== 1'b1) begin
      fails++; $display("FAIL gaps_gap: got busy %b data %h exp busy 1 data 0", tx_busy, rhs_data); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ping_pong();
    test_overlap();
    test_mid_reset();
    test_wr_gaps();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
